// File: rtl/online_softmax_acc_pkg.sv
// Shared widths and vector typedefs for the online-softmax accumulator.
// Scores are log2-domain, so a score difference is directly a right-shift amount.
package online_softmax_acc_pkg;

  localparam int OSM_NUM_CH  = 4;
  localparam int OSM_DIM     = 64;
  localparam int OSM_DATA_W  = 8;
  localparam int OSM_SCORE_W = 16;
  localparam int OSM_ACC_W   = 32;
  localparam int OSM_FRAC    = 8;

  typedef logic signed [OSM_DATA_W-1:0]    v_elem_t;
  typedef logic signed [OSM_SCORE_W-1:0]   score_t;
  typedef logic signed [OSM_ACC_W-1:0]     acc_t;
  typedef logic [OSM_DIM*OSM_DATA_W-1:0]   v_vec_t;
  typedef logic [OSM_DIM*OSM_ACC_W-1:0]    o_vec_t;

endpackage

// File: rtl/osm_lane.sv
// One rescale-and-add lane: acc_new = (first ? 0 : acc_old >>> d_old) + ((v << FRAC) >>> d_new),
// saturated to the signed ACC_W range.
module osm_lane
  import online_softmax_acc_pkg::*;
#(
  parameter int DATA_W = OSM_DATA_W,
  parameter int ACC_W  = OSM_ACC_W,
  parameter int FRAC   = OSM_FRAC,
  parameter int SH_W   = $clog2(ACC_W)
) (
  input  logic              first_eff,
  input  logic [ACC_W-1:0]  acc_old,
  input  logic [DATA_W-1:0] v,
  input  logic [SH_W-1:0]   d_old,
  input  logic [SH_W-1:0]   d_new,
  output logic [ACC_W-1:0]  acc_new,
  output logic              sat
);

  logic signed [ACC_W-1:0] old_term;
  logic signed [ACC_W-1:0] new_term;
  logic signed [ACC_W-1:0] v_ext;
  logic signed [ACC_W:0]   sum;

  always_comb begin
    v_ext = ACC_W'($signed(v));
    // if/else rather than ?: with '0 keeps the shift signed (arithmetic)
    if (first_eff) old_term = '0;
    else           old_term = $signed(acc_old) >>> d_old;
    new_term = (v_ext <<< FRAC) >>> d_new;
    sum      = {old_term[ACC_W-1], old_term} + {new_term[ACC_W-1], new_term};
    sat      = 1'b0;
    acc_new  = sum[ACC_W-1:0];
    if (sum[ACC_W] != sum[ACC_W-1]) begin
      sat = 1'b1;
      acc_new = sum[ACC_W] ? {1'b1, {(ACC_W-1){1'b0}}} : {1'b0, {(ACC_W-1){1'b1}}};
    end
  end

endmodule

// File: rtl/online_softmax_acc.sv
// Multi-channel online-softmax accumulator: per-channel running max, denominator and O*,
// emitting (O*, l) one cycle after each row's last beat.
module online_softmax_acc
  import online_softmax_acc_pkg::*;
#(
  parameter int NUM_CH  = OSM_NUM_CH,
  parameter int DIM     = OSM_DIM,
  parameter int DATA_W  = OSM_DATA_W,
  parameter int SCORE_W = OSM_SCORE_W,
  parameter int ACC_W   = OSM_ACC_W,
  parameter int FRAC    = OSM_FRAC,
  parameter int CH_W    = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [CH_W-1:0]       in_ch,
  input  logic                  in_first,
  input  logic                  in_last,
  input  logic [SCORE_W-1:0]    in_score,
  input  logic [DIM*DATA_W-1:0] in_v,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [CH_W-1:0]       out_ch,
  output logic [DIM*ACC_W-1:0]  out_o,
  output logic [ACC_W-1:0]      out_l,
  output logic                  err,
  output logic                  sat
);

  localparam int SH_W = $clog2(ACC_W);

  logic [NUM_CH-1:0]           active;
  logic signed [SCORE_W-1:0]   m_q [NUM_CH];
  logic [ACC_W-1:0]            l_q [NUM_CH];
  logic [DIM*ACC_W-1:0]        o_q [NUM_CH];

  logic                        accept;
  logic                        first_eff;
  logic                        proto_err;
  logic signed [SCORE_W-1:0]   score;
  logic signed [SCORE_W-1:0]   cur_m;
  logic signed [SCORE_W-1:0]   m_new;
  logic [ACC_W-1:0]            cur_l;
  logic [DIM*ACC_W-1:0]        cur_o;
  logic signed [SCORE_W:0]     d_old_w;
  logic signed [SCORE_W:0]     d_new_w;
  logic [SH_W-1:0]             d_old;
  logic [SH_W-1:0]             d_new;
  logic [ACC_W-1:0]            l_new;
  logic [DIM*ACC_W-1:0]        o_new;
  logic [DIM:0]                sat_vec;

  // Shift amounts beyond ACC_W-1 would flush everything anyway; clamp keeps shifter small.
  function automatic logic [SH_W-1:0] clamp_sh(input logic signed [SCORE_W:0] d);
    if (d < 0)                   return '0;
    else if (int'(d) > ACC_W-1)  return SH_W'(ACC_W-1);
    else                         return SH_W'(d);
  endfunction

  assign in_ready = !out_valid || out_ready;
  assign accept   = in_valid && in_ready;

  always_comb begin
    score     = $signed(in_score);
    cur_m     = m_q[in_ch];
    cur_l     = l_q[in_ch];
    cur_o     = o_q[in_ch];
    first_eff = in_first || !active[in_ch];
    proto_err = in_first ? active[in_ch] : !active[in_ch];
    if (first_eff)          m_new = score;
    else if (score > cur_m) m_new = score;
    else                    m_new = cur_m;
    d_old_w = (SCORE_W+1)'(m_new) - (SCORE_W+1)'(cur_m);
    d_new_w = (SCORE_W+1)'(m_new) - (SCORE_W+1)'(score);
    d_old   = clamp_sh(d_old_w);
    d_new   = clamp_sh(d_new_w);
  end

  for (genvar i = 0; i < DIM; i++) begin : g_lane
    osm_lane #(.DATA_W(DATA_W), .ACC_W(ACC_W), .FRAC(FRAC), .SH_W(SH_W)) u_lane (
      .first_eff (first_eff),
      .acc_old   (cur_o[i*ACC_W +: ACC_W]),
      .v         (in_v[i*DATA_W +: DATA_W]),
      .d_old     (d_old),
      .d_new     (d_new),
      .acc_new   (o_new[i*ACC_W +: ACC_W]),
      .sat       (sat_vec[i])
    );
  end

  // Denominator lane: same datapath with a unit weight as its "V" element.
  osm_lane #(.DATA_W(DATA_W), .ACC_W(ACC_W), .FRAC(FRAC), .SH_W(SH_W)) u_lane_l (
    .first_eff (first_eff),
    .acc_old   (cur_l),
    .v         (DATA_W'(1)),
    .d_old     (d_old),
    .d_new     (d_new),
    .acc_new   (l_new),
    .sat       (sat_vec[DIM])
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      active    <= '0;
      for (int c = 0; c < NUM_CH; c++) begin
        m_q[c] <= '0;
        l_q[c] <= '0;
        o_q[c] <= '0;
      end
      out_valid <= 1'b0;
      out_ch    <= '0;
      out_o     <= '0;
      out_l     <= '0;
      err       <= 1'b0;
      sat       <= 1'b0;
    end else begin
      if (accept) begin
        m_q[in_ch]    <= m_new;
        l_q[in_ch]    <= l_new;
        o_q[in_ch]    <= o_new;
        active[in_ch] <= !in_last;
        if (|sat_vec) sat <= 1'b1;
        if (proto_err) err <= 1'b1;
      end
      // accept implies the previous result is gone or leaving this cycle
      if (accept && in_last) begin
        out_valid <= 1'b1;
        out_ch    <= in_ch;
        out_o     <= o_new;
        out_l     <= l_new;
      end else if (out_ready) begin
        out_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_online_softmax_acc.sv
// Directed bench for online_softmax_acc (DIM=4); a second ACC_W=16 instance shares the inputs
// to exercise saturation.
module tb_online_softmax_acc;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready, in_ready16;
  logic [1:0]  in_ch = '0;
  logic        in_first = 1'b0;
  logic        in_last = 1'b0;
  logic [15:0] in_score = '0;
  logic [31:0] in_v = '0;
  logic        out_valid, out_valid16;
  logic        out_ready = 1'b1;
  logic [1:0]  out_ch, out_ch16;
  logic [127:0] out_o;
  logic [63:0]  out_o16;
  logic [31:0]  out_l;
  logic [15:0]  out_l16;
  logic        err, err16, sat, sat16;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  online_softmax_acc #(.NUM_CH(4), .DIM(4), .DATA_W(8), .SCORE_W(16), .ACC_W(32), .FRAC(8)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_ch(in_ch),
    .in_first(in_first), .in_last(in_last), .in_score(in_score), .in_v(in_v),
    .out_valid(out_valid), .out_ready(out_ready), .out_ch(out_ch), .out_o(out_o),
    .out_l(out_l), .err(err), .sat(sat)
  );

  online_softmax_acc #(.NUM_CH(4), .DIM(4), .DATA_W(8), .SCORE_W(16), .ACC_W(16), .FRAC(8)) dut16 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready16), .in_ch(in_ch),
    .in_first(in_first), .in_last(in_last), .in_score(in_score), .in_v(in_v),
    .out_valid(out_valid16), .out_ready(out_ready), .out_ch(out_ch16), .out_o(out_o16),
    .out_l(out_l16), .err(err16), .sat(sat16)
  );

  function automatic int oel(input int i);
    return int'($signed(out_o[i*32 +: 32]));
  endfunction

  task automatic drive(input int ch, input bit f, input bit l, input int s,
                       input int v0, input int v1, input int v2, input int v3);
    in_valid = 1'b1;
    in_ch    = 2'(ch);
    in_first = f;
    in_last  = l;
    in_score = 16'(s);
    in_v     = {8'(v3), 8'(v2), 8'(v1), 8'(v0)};
  endtask

  // Presents one beat and returns 1 time unit after the edge that accepts it.
  task automatic beat(input int ch, input bit f, input bit l, input int s,
                      input int v0, input int v1, input int v2, input int v3);
    drive(ch, f, l, s, v0, v1, v2, v3);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    in_first = 1'b0;
    in_last  = 1'b0;
  endtask

  task automatic test_reset;
    rst = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got %0b want 0", out_valid); end
    checks++; if (out_o !== '0 || out_l !== '0 || out_ch !== '0) begin errors++; $display("FAIL reset_out_data got o=%h l=%h ch=%0d want 0", out_o, out_l, out_ch); end
    checks++; if (err !== 1'b0 || sat !== 1'b0) begin errors++; $display("FAIL reset_flags got err=%0b sat=%0b want 0 0", err, sat); end
    rst = 1'b1;
    @(posedge clk); #1;
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready got %0b want 1", in_ready); end
  endtask

  task automatic test_single_beat;
    beat(0, 1, 1, 5, 1, 2, -3, 4);
    checks++; if (out_valid !== 1'b1 || out_ch !== 2'd0) begin errors++; $display("FAIL single_valid_ch got v=%0b ch=%0d want 1 0", out_valid, out_ch); end
    checks++; if (oel(0) !== 256 || oel(1) !== 512 || oel(2) !== -768 || oel(3) !== 1024) begin
      errors++; $display("FAIL single_o got %0d %0d %0d %0d want 256 512 -768 1024", oel(0), oel(1), oel(2), oel(3)); end
    checks++; if (out_l !== 32'd256) begin errors++; $display("FAIL single_l got %0d want 256", out_l); end
  endtask

  task automatic test_equal_scores;
    beat(1, 1, 0, 3, 1, 0, 0, 0);
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL nonlast_no_output got %0b want 0", out_valid); end
    beat(1, 0, 1, 3, 3, 0, 0, 0);
    checks++; if (out_valid !== 1'b1 || out_ch !== 2'd1) begin errors++; $display("FAIL equal_valid_ch got v=%0b ch=%0d want 1 1", out_valid, out_ch); end
    checks++; if (oel(0) !== 1024 || out_l !== 32'd512) begin errors++; $display("FAIL equal_o_l got o0=%0d l=%0d want 1024 512", oel(0), out_l); end
  endtask

  task automatic test_rescale;
    beat(2, 1, 0, 0, 4, -3, 0, 0);
    beat(2, 0, 1, 2, 0, 0, 0, 0);
    checks++; if (oel(0) !== 256 || out_l !== 32'd320) begin errors++; $display("FAIL rising_o_l got o0=%0d l=%0d want 256 320", oel(0), out_l); end
    checks++; if (oel(1) !== -192) begin errors++; $display("FAIL rising_neg_shift got %0d want -192", oel(1)); end
    beat(2, 1, 0, 2, 4, 0, 0, 0);
    beat(2, 0, 1, 0, 4, 0, 0, 0);
    checks++; if (oel(0) !== 1280 || out_l !== 32'd320) begin errors++; $display("FAIL falling_o_l got o0=%0d l=%0d want 1280 320", oel(0), out_l); end
  endtask

  task automatic test_back_to_back;
    beat(0, 1, 0, 0, 1, 0, 0, 0);
    beat(1, 1, 0, 0, 2, 0, 0, 0);
    out_ready = 1'b0;
    beat(0, 0, 1, 0, 1, 0, 0, 0);
    checks++; if (out_valid !== 1'b1 || out_ch !== 2'd0 || oel(0) !== 512 || out_l !== 32'd512) begin
      errors++; $display("FAIL interleave_first got v=%0b ch=%0d o0=%0d l=%0d want 1 0 512 512", out_valid, out_ch, oel(0), out_l); end
    drive(1, 0, 1, 0, 2, 0, 0, 0);
    repeat (3) @(posedge clk);
    #1;
    checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL stall_in_ready got %0b want 0", in_ready); end
    checks++; if (out_valid !== 1'b1 || out_ch !== 2'd0 || oel(0) !== 512 || out_l !== 32'd512) begin
      errors++; $display("FAIL stall_hold got v=%0b ch=%0d o0=%0d l=%0d want 1 0 512 512", out_valid, out_ch, oel(0), out_l); end
    out_ready = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0; in_last = 1'b0;
    checks++; if (out_valid !== 1'b1 || out_ch !== 2'd1 || oel(0) !== 1024 || out_l !== 32'd512) begin
      errors++; $display("FAIL interleave_second got v=%0b ch=%0d o0=%0d l=%0d want 1 1 1024 512", out_valid, out_ch, oel(0), out_l); end
    @(posedge clk); #1;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL transfer_clears got %0b want 0", out_valid); end
  endtask

  task automatic test_protocol_reset;
    checks++; if (err !== 1'b0 || sat16 !== 1'b0) begin errors++; $display("FAIL no_spurious_flags got err=%0b sat16=%0b want 0 0", err, sat16); end
    beat(3, 1, 0, 0, 5, 0, 0, 0);
    beat(3, 1, 1, 0, 2, 0, 0, 0);
    checks++; if (err !== 1'b1 || oel(0) !== 512 || out_l !== 32'd256) begin
      errors++; $display("FAIL restart_row got err=%0b o0=%0d l=%0d want 1 512 256", err, oel(0), out_l); end
    @(posedge clk); #1;
    beat(3, 1, 0, 0, 5, 0, 0, 0);
    rst = 1'b0;
    #1;
    checks++; if (out_valid !== 1'b0 || err !== 1'b0 || out_l !== '0) begin
      errors++; $display("FAIL midrow_reset got v=%0b err=%0b l=%0d want 0 0 0", out_valid, err, out_l); end
    @(posedge clk); @(negedge clk);
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_hold_valid got %0b want 0", out_valid); end
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    beat(3, 0, 1, 7, 2, 0, 0, 0);
    checks++; if (err !== 1'b1) begin errors++; $display("FAIL nonfirst_inactive_err got %0b want 1", err); end
    checks++; if (out_valid !== 1'b1 || out_ch !== 2'd3 || oel(0) !== 512 || out_l !== 32'd256) begin
      errors++; $display("FAIL nonfirst_as_first got v=%0b ch=%0d o0=%0d l=%0d want 1 3 512 256", out_valid, out_ch, oel(0), out_l); end
  endtask

  task automatic test_saturation;
    beat(0, 1, 0, 0, 127, 0, 0, 0);
    beat(0, 0, 1, 0, 127, 0, 0, 0);
    checks++; if (int'($signed(out_o16[15:0])) !== 32767 || sat16 !== 1'b1) begin
      errors++; $display("FAIL sat16 got o0=%0d sat=%0b want 32767 1", $signed(out_o16[15:0]), sat16); end
    checks++; if (out_l16 !== 16'd512) begin errors++; $display("FAIL sat16_l got %0d want 512", out_l16); end
    checks++; if (oel(0) !== 65024 || sat !== 1'b0) begin errors++; $display("FAIL wide_no_sat got o0=%0d sat=%0b want 65024 0", oel(0), sat); end
  endtask

  initial begin
    test_reset();
    test_single_beat();
    test_equal_scores();
    test_rescale();
    test_back_to_back();
    test_protocol_reset();
    test_saturation();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
